// File: rtl/dac_spi_serializer.sv
// Serializes one {cmd,data} word per frame onto the DAC SYNC/SCLK/DIN pins, MSB first.
// Define DAC_SPI_SKID_EN to add a one-entry holding register so a word can be queued while busy.
module dac_spi_serializer #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4,
  parameter int CMD_WIDTH  = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CMD_WIDTH-1:0]  cmd,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  dac_sync,
  output logic                  dac_sclk,
  output logic                  dac_din
);
  localparam int F     = CMD_WIDTH + DATA_WIDTH;
  localparam int IDX_W = $clog2(F);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(F - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL, GAP} state_t;

  state_t           state, state_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic             half_low, half_low_nx;
  logic [F-1:0]     shreg, shreg_nx;
  logic             sync_nx, sclk_nx, din_nx, ready_nx, busy_nx, done_nx;
  logic             accept;

`ifdef DAC_SPI_SKID_EN
  logic [F-1:0] hold, hold_nx;
  logic         hold_full, hold_full_nx;
`endif

  assign accept = valid && ready;

  always_comb begin
    // NOTE: every signal is given a default before the case so no path leaves it unassigned (no latch).
    state_nx    = state;
    cnt_nx      = cnt;
    idx_nx      = idx;
    half_low_nx = half_low;
    shreg_nx    = shreg;
`ifdef DAC_SPI_SKID_EN
    hold_nx      = hold;
    hold_full_nx = hold_full;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx    = SHIFT;
          cnt_nx      = '0;
          idx_nx      = IDX_TOP;
          half_low_nx = 1'b0;
          shreg_nx    = {cmd, data};
        end
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_nx = '0;
          if (!half_low) begin
            half_low_nx = 1'b1;
          end else if (idx == '0) begin
            state_nx    = TRAIL;
            half_low_nx = 1'b0;
          end else begin
            idx_nx      = idx - IDX_ONE;
            half_low_nx = 1'b0;
            shreg_nx    = {shreg[F-2:0], 1'b0};
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      TRAIL: begin
        if (cnt == DIV_LAST) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      GAP: begin
        // The done cycle is the first GAP cycle, so the gap length includes it.
        if (cnt == GAP_LAST) begin
          cnt_nx = '0;
`ifdef DAC_SPI_SKID_EN
          if (hold_full) begin
            state_nx     = SHIFT;
            idx_nx       = IDX_TOP;
            half_low_nx  = 1'b0;
            shreg_nx     = hold;
            hold_full_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
`else
          state_nx = IDLE;
`endif
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef DAC_SPI_SKID_EN
    // ready is low while full, so a store never collides with the hand-over above.
    if (accept && state != IDLE) begin
      hold_nx      = {cmd, data};
      hold_full_nx = 1'b1;
    end
    ready_nx = !hold_full_nx;
`else
    ready_nx = (state_nx == IDLE);
`endif
    // Pins are computed from the next state and registered, so no input reaches a pin combinationally.
    sync_nx = !(state_nx == SHIFT || state_nx == TRAIL);
    sclk_nx = !(state_nx == SHIFT && half_low_nx);
    din_nx  = (state_nx == SHIFT) && shreg_nx[F-1];
    busy_nx = (state_nx != IDLE);
    done_nx = (state == TRAIL) && (state_nx == GAP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      half_low  <= 1'b0;
      dac_sync  <= 1'b1;
      dac_sclk  <= 1'b1;
      dac_din   <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DAC_SPI_SKID_EN
      hold_full <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      half_low  <= half_low_nx;
      dac_sync  <= sync_nx;
      dac_sclk  <= sclk_nx;
      dac_din   <= din_nx;
      ready     <= ready_nx;
      busy      <= busy_nx;
      done      <= done_nx;
`ifdef DAC_SPI_SKID_EN
      hold_full <= hold_full_nx;
`endif
    end
  end

  // NOTE: word registers carry no reset; they are always loaded before being shifted out or handed over.
  always_ff @(posedge clk) begin
    shreg <= shreg_nx;
`ifdef DAC_SPI_SKID_EN
    hold  <= hold_nx;
`endif
  end
endmodule

// File: tb/tb_dac_spi_serializer.sv
// Self-checking bench for dac_spi_serializer: default instance plus a CLK_DIV=1/GAP_CYCLES=1 instance,
// pin traces decoded into frames and compared with an arithmetic timing model.
module tb_dac_spi_serializer;
  localparam int F = 24;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  a_cmd = '0,  b_cmd = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, a_busy, a_done, a_sync, a_sclk, a_din;
  logic        b_ready, b_busy, b_done, b_sync, b_sclk, b_din;

  dac_spi_serializer dut_a (
    .clk(clk), .reset_n(reset_n), .cmd(a_cmd), .data(a_data), .valid(a_valid),
    .ready(a_ready), .busy(a_busy), .done(a_done),
    .dac_sync(a_sync), .dac_sclk(a_sclk), .dac_din(a_din)
  );

  dac_spi_serializer #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .cmd(b_cmd), .data(b_data), .valid(b_valid),
    .ready(b_ready), .busy(b_busy), .done(b_done),
    .dac_sync(b_sync), .dac_sclk(b_sclk), .dac_din(b_din)
  );

  // Selected instance under observation.
  logic sel = 1'b0;
  logic m_ready, m_busy, m_done, m_sync, m_sclk, m_din;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_sync  = sel ? b_sync  : a_sync;
  assign m_sclk  = sel ? b_sclk  : a_sclk;
  assign m_din   = sel ? b_din   : a_din;

  typedef struct {
    int   cyc;
    logic sync, sclk, din, done, ready, busy;
  } smp_t;

  typedef struct {
    int          start;
    int          len;
    logic [23:0] bits;
    int          nbits;
    int          hold_err;
  } frame_t;

  smp_t        tr[$];
  frame_t      frames[$];
  int          dones[$];
  int          idle_err;
  logic [23:0] wq[$];
  int          acc_cyc[$];

  task automatic drive_in(input logic [23:0] w, input logic v);
    if (sel) begin
      b_cmd = w[23:16]; b_data = w[15:0]; b_valid = v;
    end else begin
      a_cmd = w[23:16]; a_data = w[15:0]; a_valid = v;
    end
  endtask

  task automatic select(input logic s);
    sel = s;
    @(posedge clk); #1;
  endtask

  // Presents wq in order; after each accept valid drops for delay2 cycles before the next word.
  task automatic drive(input int delay2, input int budget);
    int   n = 0;
    int   idx = 0;
    int   pend = 0;
    logic vld = 1'b1;
    logic r;
    drive_in(wq[0], 1'b1);
    while (idx < wq.size() && n < budget) begin
      r = m_ready;
      @(posedge clk); #1;
      n++;
      if (vld && r) begin
        acc_cyc.push_back(cyc);
        idx++;
        vld = 1'b0;
        drive_in(24'($urandom()), 1'b0);
        if (idx < wq.size()) begin
          pend = delay2;
          if (pend == 0) begin
            vld = 1'b1;
            drive_in(wq[idx], 1'b1);
          end
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          vld = 1'b1;
          drive_in(wq[idx], 1'b1);
        end
      end
    end
    total++;
    if (idx !== wq.size()) begin
      bad++;
      $display("FAIL drive_timeout: accepted %0d words, wanted %0d", idx, wq.size());
    end
    drive_in(24'($urandom()), 1'b0);
  endtask

  task automatic record(input int n);
    smp_t s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s.cyc = cyc; s.sync = m_sync; s.sclk = m_sclk; s.din = m_din;
      s.done = m_done; s.ready = m_ready; s.busy = m_busy;
      tr.push_back(s);
    end
  endtask

  // Splits the trace into SYNC-low frames; DIN is read at each SCLK fall, as the DAC would.
  task automatic analyze();
    frame_t cur;
    bit     in_f = 1'b0;
    frames.delete(); dones.delete(); idle_err = 0;
    cur = '{0, 0, '0, 0, 0};
    foreach (tr[i]) begin
      if (tr[i].done === 1'b1) dones.push_back(tr[i].cyc);
      if (tr[i].sync !== 1'b0) begin
        if (tr[i].sclk !== 1'b1 || tr[i].din !== 1'b0) idle_err++;
        if (in_f) begin
          frames.push_back(cur);
          in_f = 1'b0;
        end
      end else begin
        if (!in_f) begin
          in_f = 1'b1;
          cur = '{tr[i].cyc, 0, '0, 0, 0};
        end else begin
          if (tr[i-1].sclk === 1'b1 && tr[i].sclk === 1'b0) begin
            cur.bits = {cur.bits[22:0], tr[i].din};
            cur.nbits++;
          end
          if (tr[i].din !== tr[i-1].din && !(tr[i-1].sclk === 1'b0 && tr[i].sclk === 1'b1))
            cur.hold_err++;
        end
        cur.len++;
      end
    end
    if (in_f) frames.push_back(cur);
  endtask

  task automatic run_single(input string name, input logic s, input logic [23:0] w,
                            input int div, input int gap);
    int l = F * 2 * div + div;
    int a, be, re;
    logic eb, er;
    select(s);
    tr.delete(); acc_cyc.delete();
    wq = {w};
    fork
      drive(0, 50);
      record(l + gap + 8);
    join
    analyze();
    total++;
    if (acc_cyc.size() !== 1) begin
      bad++;
      $display("FAIL %s accept_count: got %0d want 1", name, acc_cyc.size());
      return;
    end
    a = acc_cyc[0];
    total++;
    if (frames.size() !== 1) begin
      bad++;
      $display("FAIL %s frame_count: got %0d want 1", name, frames.size());
    end else begin
      total++;
      if (frames[0].start !== a) begin
        bad++; $display("FAIL %s sync_fall: got cyc %0d want %0d", name, frames[0].start, a);
      end
      total++;
      if (frames[0].len !== l) begin
        bad++; $display("FAIL %s sync_low_len: got %0d want %0d", name, frames[0].len, l);
      end
      total++;
      if (frames[0].nbits !== F) begin
        bad++; $display("FAIL %s sclk_falls: got %0d want %0d", name, frames[0].nbits, F);
      end
      total++;
      if (frames[0].bits !== w) begin
        bad++; $display("FAIL %s din_word: got %06h want %06h", name, frames[0].bits, w);
      end
      total++;
      if (frames[0].hold_err !== 0) begin
        bad++; $display("FAIL %s din_hold: got %0d changes want 0", name, frames[0].hold_err);
      end
    end
    total++;
    if (idle_err !== 0) begin
      bad++; $display("FAIL %s idle_pins: got %0d bad samples want 0", name, idle_err);
    end
    total++;
    if (dones.size() !== 1) begin
      bad++; $display("FAIL %s done_count: got %0d want 1", name, dones.size());
    end else begin
      total++;
      if (dones[0] !== a + l) begin
        bad++; $display("FAIL %s done_time: got cyc %0d want %0d", name, dones[0], a + l);
      end
    end
    be = 0; re = 0;
    foreach (tr[i]) begin
      eb = (tr[i].cyc >= a) && (tr[i].cyc < a + l + gap);
`ifdef DAC_SPI_SKID_EN
      er = 1'b1;
`else
      er = !eb;
`endif
      if (tr[i].busy !== eb) be++;
      if (tr[i].ready !== er) re++;
    end
    total++;
    if (be !== 0) begin
      bad++; $display("FAIL %s busy_window: got %0d bad samples want 0", name, be);
    end
    total++;
    if (re !== 0) begin
      bad++; $display("FAIL %s ready_window: got %0d bad samples want 0", name, re);
    end
  endtask

  task automatic test_reset();
    #35;
    total++;
    if ({a_sync, a_sclk, a_din, a_ready, a_busy, a_done} !== 6'b110000) begin
      bad++; $display("FAIL reset_pins_a: got %06b want 110000", {a_sync, a_sclk, a_din, a_ready, a_busy, a_done});
    end
    total++;
    if ({b_sync, b_sclk, b_din, b_ready, b_busy, b_done} !== 6'b110000) begin
      bad++; $display("FAIL reset_pins_b: got %06b want 110000", {b_sync, b_sclk, b_din, b_ready, b_busy, b_done});
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if ({a_ready, b_ready} !== 2'b00) begin
      bad++; $display("FAIL ready_before_edge: got %02b want 00", {a_ready, b_ready});
    end
    @(posedge clk); #1;
    total++;
    if ({a_sync, a_sclk, a_din, a_ready, a_busy, a_done} !== 6'b110100) begin
      bad++; $display("FAIL release_pins_a: got %06b want 110100", {a_sync, a_sclk, a_din, a_ready, a_busy, a_done});
    end
    total++;
    if ({b_sync, b_sclk, b_din, b_ready, b_busy, b_done} !== 6'b110100) begin
      bad++; $display("FAIL release_pins_b: got %06b want 110100", {b_sync, b_sclk, b_din, b_ready, b_busy, b_done});
    end
  endtask

  task automatic test_basic();
    run_single("basic", 1'b0, 24'h30A5C3, 2, 4);
  endtask

  task automatic test_fast();
    run_single("fast", 1'b1, 24'h00FFFF, 1, 1);
  endtask

  task automatic test_back_to_back(input string name, input logic s, input int div, input int gap);
    int l = F * 2 * div + div;
    int d2, exp_acc1, exp_gap, exp_start1, g;
    logic [23:0] w0, w1;
    w0 = {8'($urandom()), 16'h0001};
    w1 = {8'($urandom()), 16'h8000};
`ifdef DAC_SPI_SKID_EN
    d2 = 9;
`else
    d2 = 0;
`endif
    select(s);
    tr.delete(); acc_cyc.delete();
    wq = {w0, w1};
    fork
      drive(d2, 2 * (l + gap) + 40);
      record(2 * (l + gap) + 30);
    join
    analyze();
    total++;
    if (acc_cyc.size() !== 2) begin
      bad++; $display("FAIL %s accept_count: got %0d want 2", name, acc_cyc.size());
      return;
    end
`ifdef DAC_SPI_SKID_EN
    exp_acc1   = acc_cyc[0] + 10;
    exp_gap    = gap;
    exp_start1 = acc_cyc[0] + l + gap;
`else
    exp_acc1   = acc_cyc[0] + l + gap + 1;
    exp_gap    = gap + 1;
    exp_start1 = exp_acc1;
`endif
    total++;
    if (acc_cyc[1] !== exp_acc1) begin
      bad++; $display("FAIL %s second_accept: got cyc %0d want %0d", name, acc_cyc[1], exp_acc1);
    end
    total++;
    if (frames.size() !== 2) begin
      bad++; $display("FAIL %s frame_count: got %0d want 2", name, frames.size());
    end else begin
      g = frames[1].start - frames[0].start - frames[0].len;
      total++;
      if (g !== exp_gap) begin
        bad++; $display("FAIL %s sync_gap: got %0d want %0d", name, g, exp_gap);
      end
      total++;
      if (frames[1].start !== exp_start1) begin
        bad++; $display("FAIL %s second_fall: got cyc %0d want %0d", name, frames[1].start, exp_start1);
      end
      total++;
      if (frames[0].bits !== w0 || frames[0].nbits !== F) begin
        bad++; $display("FAIL %s word0: got %06h/%0d want %06h/%0d", name, frames[0].bits, frames[0].nbits, w0, F);
      end
      total++;
      if (frames[1].bits !== w1 || frames[1].nbits !== F) begin
        bad++; $display("FAIL %s word1: got %06h/%0d want %06h/%0d", name, frames[1].bits, frames[1].nbits, w1, F);
      end
      total++;
      if (frames[1].len !== l) begin
        bad++; $display("FAIL %s word1_len: got %0d want %0d", name, frames[1].len, l);
      end
    end
    total++;
    if (dones.size() !== 2) begin
      bad++; $display("FAIL %s done_count: got %0d want 2", name, dones.size());
    end
  endtask

  task automatic test_reset_mid();
    int   falls = 0;
    int   done_seen = 0;
    logic prev;
    select(1'b0);
    tr.delete(); acc_cyc.delete();
    wq = {24'($urandom())};
    drive(0, 20);
    prev = m_sclk;
    for (int i = 0; i < 200 && falls < 12; i++) begin
      @(posedge clk); #1;
      if (prev === 1'b1 && m_sclk === 1'b0) falls++;
      prev = m_sclk;
    end
    total++;
    if (falls !== 12) begin
      bad++; $display("FAIL mid_reach_bit12: got %0d falls want 12", falls);
    end
    #4;
    reset_n = 1'b0;
    #1;
    total++;
    if ({a_sync, a_sclk, a_din, a_busy, a_done, a_ready} !== 6'b110000) begin
      bad++; $display("FAIL mid_async_pins: got %06b want 110000", {a_sync, a_sclk, a_din, a_busy, a_done, a_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (a_done === 1'b1) done_seen++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b0) begin
      bad++; $display("FAIL mid_ready_before_edge: got %b want 0", a_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a_done === 1'b1) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++; $display("FAIL mid_no_done: got %0d pulses want 0", done_seen);
    end
    total++;
    if ({a_sync, a_sclk, a_ready, a_busy} !== 4'b1110) begin
      bad++; $display("FAIL mid_recovered: got %04b want 1110", {a_sync, a_sclk, a_ready, a_busy});
    end
    run_single("after_reset", 1'b0, 24'h123456, 2, 4);
  endtask

  task automatic test_random();
    logic [23:0] w;
    for (int i = 0; i < 6; i++) begin
      w = 24'($urandom());
      if (i % 2 == 0) run_single("rand_a", 1'b0, w, 2, 4);
      else            run_single("rand_b", 1'b1, w, 1, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_fast();
    test_back_to_back("b2b_a", 1'b0, 2, 4);
    test_back_to_back("b2b_b", 1'b1, 1, 1);
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
